wrr_arbiter: RTL and testbench
==============================

# wrr_arbiter

Weighted round-robin arbiter that shares one resource among N requesters with a per-requester grant quantum. A requester holds the resource for up to its configured weight, in cycles, before the grant rotates. Within a quantum it is not preempted. Sits in front of the shared datapath in place of a plain one-cycle-per-turn round-robin arbiter. Adds quantum counting, grant hold and back-to-back handover.

## Interface
- N, 4, number of requesters (2..8)
- WEIGHT_W, 4, weight/credit counter width
- DEFAULT_WEIGHT, 4, reset weight of every requester (1..2^WEIGHT_W-1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N  request vector; bit i held high while requester i wants the resource
- gnt  output  N  one-hot registered grant; all-zero when idle
- gnt_valid  output  1  OR of gnt, registered
- gnt_id  output  $clog2(N)  binary index of current owner; 0 when idle
- cfg_we  input  1  weight write strobe
- cfg_sel  input  $clog2(N)  weight register index
- cfg_weight  input  WEIGHT_W  weight value written

## Operation
- Two states: IDLE (no owner) and GRANT (one owner, credit counter loaded).
- Rotating pointer ptr is the index searched first. Search order is ptr, ptr+1, …, wrapping mod N.
- IDLE: if req != 0 at an edge, the first set bit in search order becomes owner.
  - gnt, gnt_id and gnt_valid update at that edge.
  - credit <= weight[owner]. A weight of 0 is treated as 1.
  - State -> GRANT.
- GRANT, at each edge:
  - req[owner]==0: release.
  - Otherwise, credit==1: release (quantum expired).
  - Otherwise: credit <= credit-1 and the grant is held.
- On release:
  - ptr <= owner+1 mod N.
  - The same edge runs a new search over the current req with the new ptr.
  - Hit: new owner granted with fresh credit. No idle bubble; gnt changes one-hot to one-hot.
  - Miss: gnt <= 0, state -> IDLE.
- A sole requester whose quantum expires is re-granted with fresh credit. gnt stays high continuously.
- Continuous req gives exactly weight[i] consecutive gnt cycles.
- Weight writes:
  - cfg_we writes weight[cfg_sel] <= cfg_weight at the edge.
  - cfg_sel >= N is ignored.
  - A new weight applies at that requester's next credit load, never to a quantum already running.
- Requests from non-owners never shorten the current quantum.

## Timing
- Reset (async assert, released synchronously to clk by the system) sets:
  - gnt=0, gnt_valid=0, gnt_id=0
  - ptr=0, credit=0, state=IDLE
  - every weight = DEFAULT_WEIGHT
- Assertion of rst mid-grant clears gnt immediately, without waiting for clk.
- Grant latency: req rising before edge k produces gnt at edge k when idle. One cycle from request to registered grant.
- Release latency: req[owner] dropping before edge k removes or changes gnt at edge k.
- The owner's last usable cycle is the cycle in which its req is still high before that edge.
- gnt is never multi-hot, including during handover.
- A cfg write and a credit load for the same index at the same edge: the load uses the old weight.

## Configuration
- Macro WRR_WEIGHT_CFG_EN.
- Defined:
  - Weight registers are writable through cfg_we/cfg_sel/cfg_weight as above.
- Undefined:
  - No weight registers are instantiated.
  - Every weight is the constant DEFAULT_WEIGHT.
  - cfg_* ports remain on the interface but are ignored.

## Test plan
- Default weights 4, req=4'b1111 held from reset release.
  - Required: gnt 0001 for 4 cycles, then 0010×4, 0100×4, 1000×4, then 0001 again.
  - gnt_id tracks 0,1,2,3.
- cfg writes weights {1,2,3,4} for indices 0..3, then req=4'b1111.
  - Required: gnt 0001×1, 0010×2, 0100×3, 1000×4, repeating with no bubbles.
- req=4'b0100 held for 12 cycles.
  - Required: gnt=0100 continuously through two quantum expiries, gnt_valid never drops.
  - After req drops: gnt=0 at the next edge, gnt_id=0.
- Owner 1 granted with weight 4 and req=4'b1010; req[1] drops after 2 cycles.
  - Required: gnt switches 0010 -> 1000 at the next edge.
  - ptr then favours index 0 after requester 3 releases.
- rst asserted mid-grant with gnt=1000.
  - Required: gnt=0, gnt_valid=0 immediately.
  - After release with req=4'b1001: first grant is 0001 (ptr reset to 0).
- Build without WRR_WEIGHT_CFG_EN, cfg_we pulsed with cfg_weight=1 for index 0.
  - Required: requester 0 still holds 4 cycles under req=4'b0011.

Source files
------------

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with per-requester grant quantum
// Define WRR_WEIGHT_CFG_EN to make the per-requester weights writable; otherwise all weights are DEFAULT_WEIGHT.
module wrr_arbiter #(
  parameter int N              = 4,
  parameter int WEIGHT_W       = 4,
  parameter int DEFAULT_WEIGHT = 4,
  localparam int IDW           = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        gnt,
  output logic                gnt_valid,
  output logic [IDW-1:0]      gnt_id,
  input  logic                cfg_we,
  input  logic [IDW-1:0]      cfg_sel,
  input  logic [WEIGHT_W-1:0] cfg_weight
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic                gnt_valid_q;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W-1:0] sel_weight;
  logic [WEIGHT_W-1:0] load_weight;
  logic [IDW-1:0]      start;
  logic [IDW-1:0]      hit_id;
  logic                hit;
  logic                release_c;

`ifdef WRR_WEIGHT_CFG_EN
  logic [WEIGHT_W-1:0] weight_q [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
    end else if (cfg_we && (int'(cfg_sel) < N)) begin
      weight_q[cfg_sel] <= cfg_weight;
    end
  end

  // Read before this edge's write lands, so a same-edge load sees the old weight.
  assign sel_weight = weight_q[hit_id];
`else
  wire unused_cfg = ^{cfg_we, cfg_sel, cfg_weight};
  assign sel_weight = WEIGHT_W'(DEFAULT_WEIGHT);
`endif

  assign load_weight = (sel_weight == '0) ? WEIGHT_W'(1) : sel_weight;

  always_comb begin
    int idx;
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    credit_d  = credit_q;
    hit       = 1'b0;
    hit_id    = '0;
    release_c = (state_q == GRANT) && (!req[id_q] || (credit_q == WEIGHT_W'(1)));
    // A releasing owner hands the search start to its successor in the same cycle.
    if (release_c) start = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
    else           start = ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (req[IDW'(idx)]) begin
        hit    = 1'b1;
        hit_id = IDW'(idx);
      end
    end
    if (release_c) ptr_d = start;
    if ((state_q == IDLE) || release_c) begin
      if (hit) begin
        state_d        = GRANT;
        gnt_d          = '0;
        gnt_d[hit_id]  = 1'b1;
        id_d           = hit_id;
        credit_d       = load_weight;
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        id_d     = '0;
        credit_d = '0;
      end
    end else begin
      credit_d = credit_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      id_q        <= '0;
      ptr_q       <= '0;
      credit_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      credit_q    <= credit_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = id_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb/tb_wrr_arbiter.sv - self-checking bench for wrr_arbiter against a quantum-counting reference model
module tb_wrr_arbiter;

  localparam int N   = 4;
  localparam int WW  = 4;
  localparam int DW  = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           cfg_we = 1'b0;
  logic [IDW-1:0] cfg_sel = '0;
  logic [WW-1:0]  cfg_weight = '0;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner index (-1 idle), cycles held so far, quantum fixed at grant time.
  int m_owner;
  int m_used;
  int m_quota;
  int m_ptr;
  int m_w [N];

  wrr_arbiter #(.N(N), .WEIGHT_W(WW), .DEFAULT_WEIGHT(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_weight(cfg_weight)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_used = 0; m_quota = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_w[i] = DW;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic we, input int sel, input int w);
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_used >= m_quota) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_used++;
      end
    end
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_used  = 1;
          m_quota = (m_w[m_owner] == 0) ? 1 : m_w[m_owner];
        end
      end
    end
`ifdef WRR_WEIGHT_CFG_EN
    if (we && sel < N) m_w[sel] = w;
`endif
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] e;
    e = '0;
    if (m_owner >= 0) e[m_owner] = 1'b1;
    check({tag, ".gnt"}, gnt, e);
    check({tag, ".gnt_id"}, gnt_id, (m_owner < 0) ? 0 : m_owner);
    check({tag, ".gnt_valid"}, gnt_valid, (m_owner >= 0));
    check({tag, ".onehot0"}, $onehot0(gnt), 1);
  endtask

  task automatic step(input string tag, input logic [N-1:0] r, input logic we,
                      input logic [IDW-1:0] sel, input logic [WW-1:0] w);
    req = r; cfg_we = we; cfg_sel = sel; cfg_weight = w;
    @(posedge clk);
    model_edge(r, we, int'(sel), int'(w));
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; cfg_we = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] r;
    model_reset();
    do_reset();

    // Default weights, all requesting: 4 cycles each in order 0..3, then back to 0.
    for (int c = 0; c < 20; c++) begin
      step("rr_default", 4'b1111, 1'b0, '0, '0);
      check("rr_default.const", gnt, 4'b0001 << ((c / 4) % 4));
    end

    // Weights {1,2,3,4} then full request.
    do_reset();
    for (int i = 0; i < N; i++) step("cfg_wr", 4'b0000, 1'b1, IDW'(i), WW'(i + 1));
    for (int c = 0; c < 25; c++) step("rr_weighted", 4'b1111, 1'b0, '0, '0);

    // Sole requester re-granted through two quantum expiries, then released.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step("sole", 4'b0100, 1'b0, '0, '0);
      check("sole.hold", gnt, 4'b0100);
    end
    step("sole_drop", 4'b0000, 1'b0, '0, '0);
    check("sole_drop.gnt", gnt, 4'b0000);

    // Early release of owner 1 hands over to 3, then pointer favours 0.
    do_reset();
    step("early", 4'b1010, 1'b0, '0, '0);
    check("early.own1", gnt, 4'b0010);
    step("early", 4'b1010, 1'b0, '0, '0);
    step("early", 4'b1000, 1'b0, '0, '0);
    check("early.switch", gnt, 4'b1000);
    for (int c = 0; c < 5; c++) step("early_tail", 4'b1001, 1'b0, '0, '0);
    check("early.ptr0", gnt, 4'b0001);

    // Asynchronous reset mid-grant.
    do_reset();
    step("pre_rst", 4'b1000, 1'b0, '0, '0);
    step("pre_rst", 4'b1000, 1'b0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst.gnt", gnt, 4'b0000);
    check("mid_rst.valid", gnt_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst", 4'b1001, 1'b0, '0, '0);
    check("post_rst.first", gnt, 4'b0001);

    // Weight write to index 0; effect depends on the build.
    do_reset();
    step("cfg_pulse", 4'b0000, 1'b1, 2'd0, 4'd1);
    for (int c = 0; c < 10; c++) step("cfg_after", 4'b0011, 1'b0, '0, '0);

    // Randomized traffic with sticky requests and occasional weight writes.
    do_reset();
    r = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      step("rand", r, ($urandom_range(0, 9) == 0), IDW'($urandom), WW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
